// File: rtl/fft_frame_feeder_if.sv
// Bundle of the upstream sample handshake and the FFT core input bus.
// The feeder takes the slave view; the environment driving samples takes the master view.
interface fft_frame_feeder_if #(
  parameter int width = 16
);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [width-1:0] s_re;
  logic signed [width-1:0] s_im;
  logic                    din_en;
  logic signed [width-1:0] din_re;
  logic signed [width-1:0] din_im;
  logic                    frame_start;
  logic [15:0]             frames_sent;

  modport slave (
    input  s_valid, s_re, s_im,
    output s_ready, din_en, din_re, din_im, frame_start, frames_sent
  );

  modport master (
    output s_valid, s_re, s_im,
    input  s_ready, din_en, din_re, din_im, frame_start, frames_sent
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer feeding the pipelined FFT core: collects 2^NALL samples per bank
// and replays each full bank as one gap-free din_en burst.
module fft_frame_feeder #(
  parameter int width = 16,
  parameter int NALL  = 9,
  parameter int GAP   = 1
) (
  input logic              clk,
  input logic              areset,
  fft_frame_feeder_if.slave bus
);
  localparam int DEPTH = 1 << NALL;
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [NALL-1:0] widx_q, widx_d;
  logic [NALL-1:0] ridx_q, ridx_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [1:0]      full_q, full_d;
  logic            s_ready_q, s_ready_d;
  logic            din_en_q, din_en_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_end_q, frame_end_d;
  logic [15:0]     frames_sent_q, frames_sent_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

  logic [2*width-1:0] mem [2*DEPTH];
  logic [2*width-1:0] rdata_q;

  logic wr_fire;
  logic wr_wrap;
  logic rd_fire;
  logic rd_last;

  assign wr_fire = bus.s_valid && s_ready_q;
  assign wr_wrap = wr_fire && (&widx_q);
  assign rd_fire = (state_q == S_BURST);
  assign rd_last = rd_fire && (&ridx_q);

  // s_ready looks at both the current and next full flags so it drops immediately when the
  // writer wraps onto a full bank, yet only returns the cycle after the reader frees it.
  always_comb begin
    widx_d  = widx_q;
    wbank_d = wbank_q;
    full_d  = full_q;
    if (wr_fire) begin
      widx_d = widx_q + 1'b1;
      if (wr_wrap) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    if (rd_last) begin
      full_d[rbank_q] = 1'b0;
    end
    s_ready_d = !full_q[wbank_d] && !full_d[wbank_d];
  end

  always_comb begin
    state_d   = state_q;
    ridx_d    = ridx_q;
    rbank_d   = rbank_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = S_BURST;
          ridx_d  = '0;
        end
      end
      S_BURST: begin
        ridx_d = ridx_q + 1'b1;
        if (&ridx_q) begin
          rbank_d   = ~rbank_q;
          gap_cnt_d = '0;
          // Back-to-back also covers the other bank completing on this very edge.
          if (GAP > 0) begin
            state_d = S_GAP;
          end else if (full_d[~rbank_q]) begin
            state_d = S_BURST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        // The final gap cycle doubles as the idle check so the low stretch is exactly GAP long.
        if (gap_cnt_q == GW'(GAP - 1)) begin
          state_d = full_q[rbank_q] ? S_BURST : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    din_en_d      = rd_fire;
    frame_start_d = rd_fire && (ridx_q == '0);
    frame_end_d   = rd_last;
    frames_sent_d = frames_sent_q + 16'(frame_end_q);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      widx_q        <= '0;
      ridx_q        <= '0;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      full_q        <= '0;
      s_ready_q     <= 1'b0;
      din_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frames_sent_q <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      ridx_q        <= ridx_d;
      wbank_q       <= wbank_d;
      rbank_q       <= rbank_d;
      full_q        <= full_d;
      s_ready_q     <= s_ready_d;
      din_en_q      <= din_en_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frames_sent_q <= frames_sent_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !areset) begin
      mem[{wbank_q, widx_q}] <= {bus.s_re, bus.s_im};
    end
    rdata_q <= mem[{rbank_q, ridx_q}];
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.din_en      = din_en_q;
  assign bus.din_re      = din_en_q ? rdata_q[2*width-1:width] : '0;
  assign bus.din_im      = din_en_q ? rdata_q[width-1:0] : '0;
  assign bus.frame_start = frame_start_q;
  assign bus.frames_sent = frames_sent_q;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench: one feeder with a one-cycle gap and one running back-to-back,
// driven from a scenario table plus hand-written reset and backpressure sequences.
module tb_fft_frame_feeder;
  localparam int W     = 16;
  localparam int DEPTH = 512;

  typedef struct {
    int inst;
    int nsamp;
    bit sparse;
    int mode;
    int expBursts;
    int expFrames;
    int expMaxRun;
    int expMaxGap;
    int expDropAt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_m;
  logic rst_b;
  int   cyc;
  int   nTests;
  int   nFail;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_feeder_if #(.width(W)) ifm ();
  fft_frame_feeder_if #(.width(W)) ifb ();

  fft_frame_feeder #(.width(W), .NALL(9), .GAP(1)) u_main (
    .clk(clk), .areset(rst_m), .bus(ifm)
  );
  fft_frame_feeder #(.width(W), .NALL(9), .GAP(0)) u_b2b (
    .clk(clk), .areset(rst_b), .bus(ifb)
  );

  logic [2*W-1:0] sb0[$];
  logic [2*W-1:0] sb1[$];
  int xfers[2], outCnt[2], bursts[2], curRun[2], maxRun[2];
  int curGap[2], maxGap[2], dropAt[2], fillEdge[2], firstRe[2];
  bit prevEn[2], seenEn[2];
  int readyAtLast, readyAfterLast;
  bit wantAfter;
  vec_t vecs[4];

  task automatic check(input string name, input longint act, input longint exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic getReady(input int i);
    return (i == 0) ? ifm.s_ready : ifb.s_ready;
  endfunction
  function automatic logic getEn(input int i);
    return (i == 0) ? ifm.din_en : ifb.din_en;
  endfunction
  function automatic logic getFs(input int i);
    return (i == 0) ? ifm.frame_start : ifb.frame_start;
  endfunction
  function automatic logic [W-1:0] getRe(input int i);
    return (i == 0) ? ifm.din_re : ifb.din_re;
  endfunction
  function automatic logic [W-1:0] getIm(input int i);
    return (i == 0) ? ifm.din_im : ifb.din_im;
  endfunction
  function automatic logic [15:0] getFrames(input int i);
    return (i == 0) ? ifm.frames_sent : ifb.frames_sent;
  endfunction
  function automatic int sbSize(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic drive(input int i, input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
    if (i == 0) begin
      ifm.s_valid = v; ifm.s_re = re; ifm.s_im = im;
    end else begin
      ifb.s_valid = v; ifb.s_re = re; ifb.s_im = im;
    end
  endtask

  task automatic sample(input int mode, input int k, output logic [W-1:0] re, output logic [W-1:0] im);
    logic [W-1:0] bv [8];
    bv = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h7FFE, 16'h8001, 16'h5A5A};
    if (mode == 0) begin
      re = W'(k);
      im = W'(-k);
    end else begin
      re = bv[k % 8];
      im = W'(k);
    end
  endtask

  task automatic resetMon(input int i);
    if (i == 0) sb0.delete(); else sb1.delete();
    xfers[i] = 0; outCnt[i] = 0; bursts[i] = 0; curRun[i] = 0; maxRun[i] = 0;
    curGap[i] = 0; maxGap[i] = 0; dropAt[i] = -1; fillEdge[i] = 0; firstRe[i] = -1;
    prevEn[i] = 1'b0; seenEn[i] = 1'b0;
    if (i == 0) begin
      readyAtLast = -1; readyAfterLast = -1; wantAfter = 1'b0;
    end
  endtask

  // Called on every falling edge: pushes accepted samples, pops and compares burst output.
  task automatic mon(input int i, input logic rst, input logic v, input logic r,
                     input logic [W-1:0] re, input logic [W-1:0] im, input logic en,
                     input logic [W-1:0] dre, input logic [W-1:0] dim, input logic fs);
    logic [2*W-1:0] exp;
    if (rst) return;
    if (v && r) begin
      if (i == 0) sb0.push_back({re, im}); else sb1.push_back({re, im});
      xfers[i]++;
      if (xfers[i] % DEPTH == 0) fillEdge[i] = cyc + 1;
    end
    if (!r && dropAt[i] < 0 && xfers[i] > 0) dropAt[i] = xfers[i];
    if (i == 0 && wantAfter) begin
      readyAfterLast = int'(r);
      wantAfter = 1'b0;
    end
    if (fs || (en && (outCnt[i] % DEPTH == 0)))
      check("frame_start", fs, en && (outCnt[i] % DEPTH == 0));
    if (en) begin
      if (sbSize(i) == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        if (i == 0) exp = sb0.pop_front(); else exp = sb1.pop_front();
        check("din_data", {dre, dim}, exp);
      end
      if (outCnt[i] % DEPTH == 0) begin
        bursts[i]++;
        if (outCnt[i] == 0) begin
          firstRe[i] = int'(dre);
          check("first_latency", cyc - fillEdge[i], 2);
        end
      end
      if (i == 0 && outCnt[i] == DEPTH - 1) begin
        readyAtLast = int'(r);
        wantAfter = 1'b1;
      end
      if (!prevEn[i] && seenEn[i] && curGap[i] > maxGap[i]) maxGap[i] = curGap[i];
      curRun[i]++;
      if (curRun[i] > maxRun[i]) maxRun[i] = curRun[i];
      outCnt[i]++;
      seenEn[i] = 1'b1;
      curGap[i] = 0;
    end else begin
      if (prevEn[i]) check("idle_data_zero", {dre, dim}, 0);
      curRun[i] = 0;
      curGap[i]++;
    end
    prevEn[i] = en;
  endtask

  task automatic doReset(input int i);
    if (i == 0) rst_m = 1'b1; else rst_b = 1'b1;
    @(posedge clk); #1;
    if (i == 0) rst_m = 1'b0; else rst_b = 1'b0;
    resetMon(i);
  endtask

  task automatic applyStimulus(input int i, input int n, input bit sparse, input int mode);
    int k = 0;
    int guard = 0;
    logic v;
    logic fire;
    logic [W-1:0] re, im;
    while (k < n && guard < 4 * n + 100) begin
      v = sparse ? ((guard % 2) == 0) : 1'b1;
      sample(mode, k, re, im);
      drive(i, v, re, im);
      @(negedge clk);
      fire = v && getReady(i);
      @(posedge clk); #1;
      if (fire) k++;
      guard++;
    end
    if (k < n) check("stim_timeout", k, n);
    drive(i, 1'b0, '0, '0);
  endtask

  task automatic waitFrames(input int i, input int n);
    int b = 0;
    while (getFrames(i) != 16'(n) && b < 4000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 4000) check("wait_frames_timeout", getFrames(i), n);
    repeat (8) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkResetState(input int i);
    check("rst_din_en", getEn(i), 0);
    check("rst_din_re", getRe(i), 0);
    check("rst_din_im", getIm(i), 0);
    check("rst_s_ready", getReady(i), 0);
    check("rst_frame_start", getFs(i), 0);
    check("rst_frames_sent", getFrames(i), 0);
  endtask

  task automatic checkOutput(input vec_t v);
    check("bursts", bursts[v.inst], v.expBursts);
    check("frames_sent", getFrames(v.inst), v.expFrames);
    check("max_run", maxRun[v.inst], v.expMaxRun);
    if (v.expMaxGap >= 0) check("max_gap", maxGap[v.inst], v.expMaxGap);
    check("ready_drop_at", dropAt[v.inst], v.expDropAt);
    check("sb_left", sbSize(v.inst), 0);
    check("xfers", xfers[v.inst], v.nsamp);
  endtask

  initial begin
    int base;
    int b;
    // inst, nsamp, sparse, mode, bursts, frames, maxRun, maxGap, dropAt
    vecs[0] = '{0, 512,  1'b0, 0, 1, 1, 512,  0, -1};
    vecs[1] = '{0, 1536, 1'b0, 0, 3, 3, 512,  1, 1024};
    vecs[2] = '{0, 1024, 1'b1, 0, 2, 2, 512, -1, -1};
    vecs[3] = '{1, 1024, 1'b0, 0, 2, 2, 1024, 0, 1024};

    rst_m = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    resetMon(0);
    resetMon(1);
    fork
      forever begin
        @(negedge clk);
        mon(0, rst_m, ifm.s_valid, ifm.s_ready, ifm.s_re, ifm.s_im,
            ifm.din_en, ifm.din_re, ifm.din_im, ifm.frame_start);
        mon(1, rst_b, ifb.s_valid, ifb.s_ready, ifb.s_re, ifb.s_im,
            ifb.din_en, ifb.din_re, ifb.din_im, ifb.frame_start);
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    checkResetState(0);
    checkResetState(1);
    rst_m = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release_m", getReady(0), 1);
    check("ready_after_release_b", getReady(1), 1);

    for (int n = 0; n < 4; n++) begin
      $display("[TB] scenario %0d: inst %0d, %0d samples, sparse %0d", n, vecs[n].inst, vecs[n].nsamp, vecs[n].sparse);
      doReset(vecs[n].inst);
      applyStimulus(vecs[n].inst, vecs[n].nsamp, vecs[n].sparse, vecs[n].mode);
      waitFrames(vecs[n].inst, vecs[n].expFrames);
      checkOutput(vecs[n]);
    end

    $display("[TB] backpressure with boundary values");
    doReset(0);
    applyStimulus(0, 1536, 1'b0, 1);
    waitFrames(0, 3);
    check("bp_ready_at_last", readyAtLast, 0);
    check("bp_ready_after_last", readyAfterLast, 1);
    check("bp_frames_sent", getFrames(0), 3);
    check("bp_sb_left", sbSize(0), 0);
    check("bp_xfers", xfers[0], 1536);

    $display("[TB] reset in mid-burst");
    base = outCnt[0];
    applyStimulus(0, 512, 1'b0, 0);
    b = 0;
    while (outCnt[0] < base + 100 && b < 3000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 3000) check("midburst_wait_timeout", outCnt[0] - base, 100);
    check("pre_reset_frames", getFrames(0), 3);
    rst_m = 1'b1;
    @(posedge clk); #1;
    check("midrst_din_en", getEn(0), 0);
    check("midrst_frames_sent", getFrames(0), 0);
    check("midrst_din_re", getRe(0), 0);
    rst_m = 1'b0;
    resetMon(0);
    @(posedge clk); #1;
    check("midrst_ready_release", getReady(0), 1);
    applyStimulus(0, 512, 1'b0, 0);
    waitFrames(0, 1);
    check("fresh_frames_sent", getFrames(0), 1);
    check("fresh_bursts", bursts[0], 1);
    check("fresh_max_run", maxRun[0], 512);
    check("fresh_first_re", firstRe[0], 0);
    check("fresh_sb_left", sbSize(0), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
